fibonacci_lanes: RTL
====================

FIBONACCI_LANES -- requirements
Module: fibonacci_lanes

Interface
REQ-001 SHALL have parameter W, default 16: term width in bits, legal range 4..64.
REQ-002 SHALL have parameter LANES, default 2: terms per output beat, legal range 1..4.
REQ-003 SHALL have parameter CW, default 16: width of the term-count input.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1: single-cycle request for a new sequence; honoured only in IDLE.
REQ-007 SHALL have port seed0, input, W: first term F0 of the sequence, sampled with start.
REQ-008 SHALL have port seed1, input, W: second term F1 of the sequence, sampled with start.
REQ-009 SHALL have port n_terms, input, CW: total number of terms to emit, sampled with start.
REQ-010 SHALL have port abort, input, 1: synchronous abort; returns the block to IDLE from any state.
REQ-011 SHALL have port out_valid, output, 1: the current beat is valid.
REQ-012 SHALL have port out_ready, input, 1: the consumer accepts the beat.
REQ-013 SHALL have port out_data, output, LANES*W: lane i at bits [i*W +: W] carries term F(k+i).
REQ-014 SHALL have port out_keep, output, LANES: per-lane valid mask; lanes form a contiguous run from lane 0.
REQ-015 SHALL have port out_last, output, 1: marks the final beat of the sequence.
REQ-016 SHALL have port ovf, output, 1: sticky flag; set when any emitted term exceeded 2^W-1.
REQ-017 SHALL have port busy, output, 1: high in the RUN and DONE states.
REQ-018 SHALL have port done, output, 1: one-cycle pulse when a sequence completes.

Function
REQ-019 SHALL implement FSM states IDLE, RUN and DONE.
REQ-020 SHALL transition IDLE->RUN on start with n_terms>0, and IDLE->DONE on start with n_terms==0.
REQ-021 SHALL transition RUN->DONE on the cycle the handshake accepts the beat carrying out_last.
REQ-022 SHALL transition DONE->IDLE unconditionally after one cycle, pulsing done during DONE.
REQ-023 SHALL, on abort, return to IDLE next cycle from any state, with priority over start and the handshake, without asserting done, and with ovf cleared.
REQ-024 SHALL assert out_valid beginning the cycle after the start that enters RUN, i.e. with one-cycle latency.
REQ-025 SHALL emit terms in order F0, F1, F2 = F0+F1, ..., with F(j+2) = F(j) + F(j+1) mod 2^W.
REQ-026 SHALL advance the sequence by LANES terms per accepted beat (out_valid && out_ready).
REQ-027 SHALL hold out_data, out_keep and out_last stable while out_valid && !out_ready.
REQ-028 SHALL set out_keep to all ones on every beat except the last.
REQ-029 SHALL, on the last beat, set out_keep so that its popcount equals the number of remaining terms (1..LANES).
REQ-030 SHALL drive unused lanes on the last beat with the continuing sequence values; consumers ignore them.
REQ-031 SHALL compute each beat's terms with a combinational adder chain from two registered terms (a, b).
REQ-032 SHALL compute the next state from terms LANES and LANES+1 of that chain.
REQ-033 SHALL set ovf when any adder in the chain carries out for a kept lane of an accepted beat.
REQ-034 SHALL hold ovf sticky until the next honoured start or abort.
REQ-035 SHALL ignore start while the FSM is in RUN or DONE.
REQ-036 SHALL emit a single beat with out_last when n_terms <= LANES.
REQ-037 SHALL treat n_terms as unsigned with no upper limit other than 2^CW-1.

Reset
REQ-038 SHALL, with rst_n low, asynchronously force the FSM to IDLE, set out_valid, out_last, ovf, busy and done to 0, and set out_data and out_keep to 0.
REQ-039 SHALL, on rst_n asserted mid-sequence, discard the sequence; after release the block waits for a new start.

Structure
REQ-040 SHALL define the FSM state enum (IDLE, RUN, DONE) in shared package fib_pkg.
REQ-041 SHALL define in fib_pkg a function computing the out_keep mask from a remaining-term count and LANES.
REQ-042 SHALL factor the adder chain into sub-module fib_step, parameterised by W and LANES, taking (a, b) and producing LANES terms, next (a, b) and per-term carry flags.

Verification
REQ-043 SHALL check: W=16, LANES=2, seeds 1,1, n_terms=6, ready always high -> beats {1,1}, {2,3}, {5,8}; keep=11 on every beat; last on beat 3; done pulses one cycle later.
REQ-044 SHALL check: LANES=4, seeds 0,1, n_terms=5 -> beat {0,1,1,2} with keep=1111, then beat with lane0=3, keep=0001 and last.
REQ-045 SHALL check: out_ready held low 3 cycles mid-sequence -> out_data held stable; the sequence resumes without skipping or duplicating terms.
REQ-046 SHALL check: W=8, LANES=1, seeds 1,1, n_terms=14 -> ovf rises on term 14 (377 mod 256 = 121); ovf stays high until the next start.
REQ-047 SHALL check: abort on the 2nd beat -> out_valid low next cycle, no done pulse; a start issued during RUN is ignored.
REQ-048 SHALL check: n_terms=0 -> no beats, done pulses one cycle after start; rst_n pulsed mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared types and helpers for the multi-lane Fibonacci generator.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int unsigned MAX_LANES = 4;

    // Contiguous run of ones from lane 0, rem lanes long, clipped to lanes.
    function automatic logic [MAX_LANES-1:0] keep_mask(
        input int unsigned rem,
        input int unsigned lanes
    );
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            m[i] = (i < rem) && (i < lanes);
        end
        return m;
    endfunction

endpackage

// File: rtl/fibonacci_lanes_step.sv
// Combinational adder chain: LANES output terms plus the next (a, b) pair.
module fib_step #(
    parameter int W     = 16,
    parameter int LANES = 2
) (
    input  logic [W-1:0]       a,
    input  logic [W-1:0]       b,
    output logic [LANES*W-1:0] terms,
    output logic [W-1:0]       next_a,
    output logic [W-1:0]       next_b,
    output logic [LANES+1:0]   carry
);

    logic [W-1:0] t [LANES+2];

    always_comb begin
        t[0]  = a;
        t[1]  = b;
        carry = '0;
        for (int i = 2; i < LANES + 2; i++) begin
            {carry[i], t[i]} = {1'b0, t[i-2]} + {1'b0, t[i-1]};
        end
        terms = '0;
        for (int i = 0; i < LANES; i++) begin
            terms[i*W +: W] = t[i];
        end
        next_a = t[LANES];
        next_b = t[LANES+1];
    end

endmodule

// File: rtl/fibonacci_lanes.sv
// Streams a Fibonacci sequence LANES terms per beat over valid/ready.
module fibonacci_lanes
    import fib_pkg::*;
#(
    parameter int W     = 16,
    parameter int LANES = 2,
    parameter int CW    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [W-1:0]       seed0,
    input  logic [W-1:0]       seed1,
    input  logic [CW-1:0]      n_terms,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out_data,
    output logic [LANES-1:0]   out_keep,
    output logic               out_last,
    output logic               ovf,
    output logic               busy,
    output logic               done
);

    state_e        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          ca_q, ca_d;
    logic          cb_q, cb_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          ovf_q, ovf_d;

    logic [LANES*W-1:0] terms;
    logic [W-1:0]       next_a;
    logic [W-1:0]       next_b;
    logic [LANES+1:0]   carry;
    logic [LANES+1:0]   eff;
    logic               last;
    logic [LANES-1:0]   keep;

    fib_step #(
        .W     (W),
        .LANES (LANES)
    ) u_step (
        .a      (a_q),
        .b      (b_q),
        .terms  (terms),
        .next_a (next_a),
        .next_b (next_b),
        .carry  (carry)
    );

    // a and b may themselves be wrapped results of the previous beat.
    assign eff  = carry | {{LANES{1'b0}}, cb_q, ca_q};
    assign last = rem_q <= CW'(LANES);
    assign keep = LANES'(keep_mask(last ? 32'(rem_q) : LANES, LANES));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ca_d    = ca_q;
        cb_d    = cb_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = seed0;
                    b_d     = seed1;
                    ca_d    = 1'b0;
                    cb_d    = 1'b0;
                    rem_d   = n_terms;
                    ovf_d   = 1'b0;
                    state_d = (n_terms == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (out_ready) begin
                    a_d  = next_a;
                    b_d  = next_b;
                    ca_d = eff[LANES];
                    cb_d = eff[LANES+1];
                    if (|(eff[LANES-1:0] & keep)) begin
                        ovf_d = 1'b1;
                    end
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        rem_d = rem_q - CW'(LANES);
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ca_q    <= 1'b0;
            cb_q    <= 1'b0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ca_q    <= ca_d;
            cb_q    <= cb_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = (state_q == RUN);
    assign out_data  = out_valid ? terms : '0;
    assign out_keep  = out_valid ? keep : '0;
    assign out_last  = out_valid && last;
    assign ovf       = ovf_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule
